// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: PC register link, redirect, imem request/response and decode output.
// Latency: none, signal grouping only.
// Backpressure: imem_req_ready stalls issue, instr_ready stalls the decode FIFO head.
interface instr_fetch_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] PCNext;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [WIDTH-1:0] imem_req_addr;
   logic             imem_rsp_valid;
   logic [31:0]      imem_rsp_data;
   logic             instr_valid;
   logic             instr_ready;
   logic [31:0]      instr_data;
   logic [WIDTH-1:0] instr_pc;

   // fetch unit side
   modport master (
      input  PC, redirect_valid, redirect_pc, imem_req_ready,
             imem_rsp_valid, imem_rsp_data, instr_ready,
      output PCNext, imem_req_valid, imem_req_addr,
             instr_valid, instr_data, instr_pc
   );

   // surrounding pipeline / memory side
   modport slave (
      output PC, redirect_valid, redirect_pc, imem_req_ready,
             imem_rsp_valid, imem_rsp_data, instr_ready,
      input  PCNext, imem_req_valid, imem_req_addr,
             instr_valid, instr_data, instr_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: steers PCNext, keeps one imem request in flight, queues {pc,instr} for decode.
// Latency: PCNext/request are combinational; a response at cycle N shows on instr_* from N+1.
// Backpressure: no issue while the FIFO is full or a request is outstanding; decode pops on instr_ready.
module instr_fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               DEPTH    = 2
) (
   input logic               clk,
   input logic               rst_n,
   instr_fetch_unit_if.master bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // REQ: idle, WAIT: response expected, DROP: response expected but stale
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] req_pc;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] fifo_pc  [DEPTH];
   logic [31:0]      fifo_dat [DEPTH];
   logic             req_vld;
   logic             req_hs;
   logic             push;
   logic             pop;
   logic             fifo_full;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign fifo_full = (count == CW'(DEPTH));
   assign req_hs    = req_vld && bus.imem_req_ready;
   // a response that coincides with a redirect belongs to the old path
   assign push      = (state == S_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
   assign pop       = (count != '0) && bus.instr_ready;

   assign bus.imem_req_valid = req_vld;
   assign bus.imem_req_addr  = bus.PC;
   assign bus.instr_valid    = (count != '0);
   assign bus.instr_data     = fifo_dat[rd_ptr];
   assign bus.instr_pc       = fifo_pc[rd_ptr];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_REQ;
      else        state <= state_nxt;
   end

   // next-state: redirect turns an outstanding WAIT into DROP unless the response is already here
   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   if (req_hs) state_nxt = S_WAIT;
         S_WAIT: begin
            if (bus.imem_rsp_valid)      state_nxt = S_REQ;
            else if (bus.redirect_valid) state_nxt = S_DROP;
         end
         S_DROP:  if (bus.imem_rsp_valid) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   // outputs: request issue and PC steering; redirect outranks everything, reset outranks redirect
   always_comb begin
      req_vld    = 1'b0;
      bus.PCNext = bus.PC;
      if (!rst_n) begin
         bus.PCNext = RESET_PC;
      end else begin
         req_vld = (state == S_REQ) && !fifo_full && !bus.redirect_valid;
         if (bus.redirect_valid)                  bus.PCNext = bus.redirect_pc;
         else if (req_vld && bus.imem_req_ready)  bus.PCNext = bus.PC + WIDTH'(4);
      end
   end

   // remember which PC the outstanding request belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      req_pc <= '0;
      else if (req_hs) req_pc <= bus.PC;
   end

   // FIFO pointers and occupancy; redirect empties the queue regardless of pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents only matter behind a nonzero count, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]  <= req_pc;
         fifo_dat[wr_ptr] <= bus.imem_rsp_data;
      end
   end

endmodule
